// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and the round-robin search helper for axis_packet_arbiter.
package axis_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned REQ_IDX_W = 4;

    // First set bit of req_mask searching upward from last_idx+1, modulo num_req;
    // last_idx itself is tried last. Returns last_idx when the mask is empty.
    function automatic logic [REQ_IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0]   req_mask,
        input logic [REQ_IDX_W-1:0] last_idx,
        input int unsigned          num_req
    );
        logic [REQ_IDX_W:0] idx;
        logic               found;
        rr_next = last_idx;
        found   = 1'b0;
        for (int unsigned off = 1; off <= MAX_REQ; off++) begin
            idx = {1'b0, last_idx} + (REQ_IDX_W+1)'(off);
            if (idx >= (REQ_IDX_W+1)'(num_req)) begin
                idx = idx - (REQ_IDX_W+1)'(num_req);
            end
            if (!found && (off <= num_req) && req_mask[idx[REQ_IDX_W-1:0]]) begin
                rr_next = idx[REQ_IDX_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle with LANES parallel channels; LANES=1 for a single stream.
interface axis_packet_arbiter_if #(
    parameter int unsigned LANES       = 1,
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned TDEST_WIDTH = 4
);

    logic [LANES-1:0]                  tvalid;
    logic [LANES-1:0]                  tready;
    logic [LANES-1:0][TDATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]                  tlast;
    logic [LANES-1:0][TID_WIDTH-1:0]   tid;
    logic [LANES-1:0][TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);

endinterface

// File: rtl/axis_reg_slice.sv
// One-entry valid/ready register slice; sustains one beat per cycle when drained.
module axis_reg_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter of NUM_REQ AXI-Stream requesters onto one port.
// Optional per-requester packet counters: define AXIS_PACKET_ARBITER_PKT_COUNT_EN.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TAG_SOURCE  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axis_packet_arbiter_if.slave       s,
    axis_packet_arbiter_if.master      m,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       busy
`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
    ,
    output logic [NUM_REQ-1:0][31:0]   pkt_count
`endif
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned PAYLOAD_W = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;

    arb_state_t           state;
    logic                 slice_ready;
    logic                 accept;
    logic                 accept_last;
    logic [IDX_W-1:0]     next_idx;
    logic [TID_WIDTH-1:0] beat_tid;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_valid;

    assign next_idx = IDX_W'(rr_next(MAX_REQ'(s.tvalid), REQ_IDX_W'(grant_idx), NUM_REQ));

    assign accept      = (state == LOCKED) && s.tvalid[grant_idx] && slice_ready;
    assign accept_last = accept && s.tlast[grant_idx];

    always_comb begin
        s.tready = '0;
        if (state == LOCKED) begin
            s.tready[grant_idx] = slice_ready;
        end
    end

    generate
        if (TAG_SOURCE != 0) begin : g_tag_source
            assign beat_tid = TID_WIDTH'(grant_idx);
        end else begin : g_pass_tid
            assign beat_tid = s.tid[grant_idx];
        end
    endgenerate

    assign in_payload = {s.tdata[grant_idx], s.tlast[grant_idx], beat_tid, s.tdest[grant_idx]};

    // Arbitration happens only in IDLE, so a grant cannot move until tlast is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= IDX_W'(NUM_REQ - 1);
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s.tvalid) begin
                        grant_idx <= next_idx;
                        state     <= LOCKED;
                        busy      <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (accept_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    axis_reg_slice #(
        .WIDTH (PAYLOAD_W)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_data   (in_payload),
        .in_ready  (slice_ready),
        .out_valid (out_valid),
        .out_data  (out_payload),
        .out_ready (m.tready[0])
    );

    assign m.tvalid[0] = out_valid;
    assign {m.tdata[0], m.tlast[0], m.tid[0], m.tdest[0]} = out_payload;

`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept_last && (grant_idx == IDX_W'(i))) begin
                    pkt_count[i] <= pkt_count[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
